// File: rtl/mips_pkg.sv
// Shared encodings and types for the 5-stage core: writeback source,
// load type, register index and the MEM/WB pipeline register layout.
package mips_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [1:0] WBSEL_ALU  = 2'd0;
  localparam logic [1:0] WBSEL_MEM  = 2'd1;
  localparam logic [1:0] WBSEL_LINK = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  // MEM/WB register contents; mis marks a misaligned load awaiting its adel pulse.
  typedef struct packed {
    logic        valid;
    logic        fresh;
    logic        regwrite;
    logic        mis;
    reg_idx_t    rd;
    logic [1:0]  wbsel;
    logic [31:0] wd;
  } memwb_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction with sign/zero extension and alignment check.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  ldtype_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = 8'h00;
    half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o       = rdata_i;
    misaligned_o = 1'b0;
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    case (ldtype_i)
      LD_LH: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      LD_LHU: begin
        data_o       = {16'h0000, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      LD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data_o = {24'h000000, byte_sel};
      // LW and every unassigned code behave as a full-word load.
      default: begin
        data_o       = rdata_i;
        misaligned_o = (addr_lo_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback data formation, register-file write
// port, misaligned-load exception pulse and retired-instruction counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_regwrite,
  input  logic [4:0]       m_rd,
  input  logic [1:0]       m_wbsel,
  input  logic [2:0]       m_ldtype,
  input  logic [DW-1:0]    m_alu,
  input  logic [DW-1:0]    m_pc8,
  input  logic [DW-1:0]    m_rdata,
  output logic             gpr_we,
  output logic [4:0]       gpr_a3,
  output logic [DW-1:0]    gpr_wd,
  output logic             adel,
  output logic [CNT_W-1:0] instret
);

  memwb_t           wb_q, wb_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [31:0]      ld_data;
  logic             ld_mis;
  logic             capture;
  logic             take;
  logic             mis;
  logic [31:0]      wdata;

  load_align u_load_align (
    .rdata_i      (m_rdata),
    .addr_lo_i    (m_alu[1:0]),
    .ldtype_i     (m_ldtype),
    .data_o       (ld_data),
    .misaligned_o (ld_mis)
  );

  always_comb begin
    wb_d      = wb_q;
    instret_d = instret_q;
    // flush overrides stall so a killed instruction never lingers in the register
    capture   = ~stall | flush;
    take      = m_valid & ~flush;
    mis       = (m_wbsel == WBSEL_MEM) & ld_mis;
    case (m_wbsel)
      WBSEL_MEM:  wdata = ld_data;
      WBSEL_LINK: wdata = m_pc8;
      default:    wdata = m_alu;
    endcase
    if (capture) begin
      wb_d.valid    = take;
      wb_d.fresh    = take;
      wb_d.regwrite = m_regwrite & ~mis;
      wb_d.mis      = mis;
      wb_d.rd       = m_rd;
      wb_d.wbsel    = m_wbsel;
      wb_d.wd       = wdata;
      // counted on entry so instret already includes the instruction while it is fresh
      if (take) instret_d = instret_q + CNT_W'(1);
    end else begin
      wb_d.fresh = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q      <= '0;
      instret_q <= '0;
    end else begin
      wb_q      <= wb_d;
      instret_q <= instret_d;
    end
  end

  assign gpr_we  = wb_q.valid & wb_q.fresh & wb_q.regwrite & (wb_q.rd != 5'd0);
  assign gpr_a3  = wb_q.rd;
  assign gpr_wd  = wb_q.wd;
  assign adel    = wb_q.valid & wb_q.fresh & wb_q.mis;
  assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of back-to-back vectors checked through an
// expected queue, plus hand sequences for stall, flush and async reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, m_valid, m_regwrite;
  logic [4:0]  m_rd;
  logic [1:0]  m_wbsel;
  logic [2:0]  m_ldtype;
  logic [31:0] m_alu, m_pc8, m_rdata;
  logic        gpr_we, adel;
  logic [4:0]  gpr_a3;
  logic [31:0] gpr_wd, instret;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = '0;

  // {instret, adel, we, a3, wd}
  logic [70:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [1:0]  wbsel;
    logic [2:0]  ldtype;
    logic [31:0] alu;
    logic [31:0] pc8;
    logic [31:0] rdata;
    logic        exp_we;
    logic        exp_adel;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  wb_stage #(.DW(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_rd(m_rd),
    .m_wbsel(m_wbsel), .m_ldtype(m_ldtype), .m_alu(m_alu),
    .m_pc8(m_pc8), .m_rdata(m_rdata),
    .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd),
    .adel(adel), .instret(instret)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] rd,
                              input logic [1:0] ws, input logic [2:0] lt,
                              input logic [31:0] alu, input logic [31:0] pc8,
                              input logic we, input logic ad, input logic [31:0] wd);
    vec_t t;
    t.valid = v; t.regwrite = rw; t.rd = rd; t.wbsel = ws; t.ldtype = lt;
    t.alu = alu; t.pc8 = pc8; t.rdata = 32'h80FF7F01;
    t.exp_we = we; t.exp_adel = ad; t.exp_wd = wd;
    return t;
  endfunction

  task automatic idle_inputs();
    stall = 0; flush = 0; m_valid = 0; m_regwrite = 0; m_rd = 0;
    m_wbsel = 0; m_ldtype = 0; m_alu = 0; m_pc8 = 0; m_rdata = 0;
  endtask

  task automatic drive_vec(input vec_t t);
    m_valid = t.valid; m_regwrite = t.regwrite; m_rd = t.rd; m_wbsel = t.wbsel;
    m_ldtype = t.ldtype; m_alu = t.alu; m_pc8 = t.pc8; m_rdata = t.rdata;
    if (t.valid) exp_cnt = exp_cnt + 1;
    exp_q.push_back({exp_cnt, t.exp_adel, t.exp_we, t.rd, t.exp_wd});
  endtask

  task automatic pop_check();
    logic [70:0] e;
    e = exp_q.pop_front();
    check("vec_we", {31'd0, gpr_we}, {31'd0, e[37]});
    check("vec_adel", {31'd0, adel}, {31'd0, e[38]});
    check("vec_instret", instret, e[70:39]);
    if (e[37]) begin
      check("vec_a3", {27'd0, gpr_a3}, {27'd0, e[36:32]});
      check("vec_wd", gpr_wd, e[31:0]);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 5,  WB_ALU(),  3'd0, 32'h00001234, 32'h0, 1, 0, 32'h00001234);
    vecs[1]  = mk(1, 1, 6,  2'd1, 3'd3, 32'h00002003, 32'h0, 1, 0, 32'hFFFFFF80);
    vecs[2]  = mk(1, 1, 7,  2'd1, 3'd4, 32'h00002003, 32'h0, 1, 0, 32'h00000080);
    vecs[3]  = mk(1, 1, 8,  2'd1, 3'd1, 32'h00002002, 32'h0, 1, 0, 32'hFFFF80FF);
    vecs[4]  = mk(1, 1, 9,  2'd1, 3'd2, 32'h00002000, 32'h0, 1, 0, 32'h00007F01);
    vecs[5]  = mk(1, 1, 10, 2'd1, 3'd3, 32'h00002001, 32'h0, 1, 0, 32'h0000007F);
    vecs[6]  = mk(1, 1, 11, 2'd1, 3'd0, 32'h00002000, 32'h0, 1, 0, 32'h80FF7F01);
    vecs[7]  = mk(1, 1, 12, 2'd1, 3'd0, 32'h00001002, 32'h0, 0, 1, 32'h0);
    vecs[8]  = mk(1, 1, 13, 2'd1, 3'd1, 32'h00001001, 32'h0, 0, 1, 32'h0);
    vecs[9]  = mk(1, 1, 0,  2'd2, 3'd0, 32'h00000000, 32'h00400008, 0, 0, 32'h0);
    vecs[10] = mk(1, 1, 14, 2'd1, 3'd7, 32'h00002000, 32'h0, 1, 0, 32'h80FF7F01);
    vecs[11] = mk(1, 1, 15, 2'd3, 3'd3, 32'h0000ABCD, 32'h0, 1, 0, 32'h0000ABCD);
    vecs[12] = mk(1, 1, 16, 2'd1, 3'd2, 32'h00001003, 32'h0, 0, 1, 32'h0);
    vecs[13] = mk(1, 1, 17, 2'd1, 3'd4, 32'h00002002, 32'h0, 1, 0, 32'h000000FF);
    vecs[14] = mk(1, 0, 18, 2'd0, 3'd0, 32'h00005555, 32'h0, 0, 0, 32'h0);
    vecs[15] = mk(0, 1, 19, 2'd0, 3'd0, 32'h00006666, 32'h0, 0, 0, 32'h0);
    vecs[16] = mk(1, 1, 20, 2'd2, 3'd0, 32'h00001002, 32'h00400010, 1, 0, 32'h00400010);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_we", {31'd0, gpr_we}, 32'd0);
    check("rst_a3", {27'd0, gpr_a3}, 32'd0);
    check("rst_wd", gpr_wd, 32'd0);
    check("rst_adel", {31'd0, adel}, 32'd0);
    check("rst_instret", instret, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) pop_check();
      drive_vec(vecs[i]);
    end
    @(negedge clk);
    pop_check();
    idle_inputs();

    // stall after a write: one write, one retire, data held
    @(negedge clk);
    m_valid = 1; m_regwrite = 1; m_rd = 7; m_wbsel = 2'd0; m_alu = 32'h00000777;
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check("stall_we0", {31'd0, gpr_we}, 32'd1);
    check("stall_wd0", gpr_wd, 32'h00000777);
    check("stall_cnt0", instret, exp_cnt);
    stall = 1; m_alu = 32'hDEADBEEF; m_rd = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_we", {31'd0, gpr_we}, 32'd0);
      check("stall_wd", gpr_wd, 32'h00000777);
      check("stall_a3", {27'd0, gpr_a3}, 32'd7);
      check("stall_cnt", instret, exp_cnt);
    end
    idle_inputs();

    // misaligned LW held by stall: adel only on the fresh cycle
    @(negedge clk);
    m_valid = 1; m_regwrite = 1; m_rd = 4; m_wbsel = 2'd1; m_ldtype = 3'd0; m_alu = 32'h00001002;
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    check("mis_adel0", {31'd0, adel}, 32'd1);
    check("mis_we0", {31'd0, gpr_we}, 32'd0);
    check("mis_cnt0", instret, exp_cnt);
    stall = 1; m_valid = 0;
    repeat (2) begin
      @(negedge clk);
      check("mis_adel", {31'd0, adel}, 32'd0);
      check("mis_cnt", instret, exp_cnt);
    end
    idle_inputs();

    // flush wins over stall
    @(negedge clk);
    m_valid = 1; m_regwrite = 1; m_rd = 9; m_alu = 32'h00000999; flush = 1; stall = 1;
    @(negedge clk);
    check("flush_we", {31'd0, gpr_we}, 32'd0);
    check("flush_adel", {31'd0, adel}, 32'd0);
    check("flush_cnt", instret, exp_cnt);
    idle_inputs();

    // asynchronous reset while a write is visible
    @(negedge clk);
    m_valid = 1; m_regwrite = 1; m_rd = 3; m_alu = 32'h00000033;
    exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #2;
    check("ar_we_pre", {31'd0, gpr_we}, 32'd1);
    check("ar_cnt_pre", instret, exp_cnt);
    reset = 1'b1;
    #1;
    check("ar_we", {31'd0, gpr_we}, 32'd0);
    check("ar_adel", {31'd0, adel}, 32'd0);
    check("ar_cnt", instret, 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    check("ar_we_post", {31'd0, gpr_we}, 32'd0);
    check("ar_cnt_post", instret, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic [1:0] WB_ALU();
    return 2'd0;
  endfunction

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback-data formation for the 5-stage core.
- Drives the write port of the general-purpose register file (we, a3, wd) and exposes the same triple to the hazard/forwarding logic.
- Performs load byte/halfword extraction with sign/zero extension, writeback source selection, misaligned-load detection and retired-instruction counting.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  kill the instruction being captured this cycle.
- m_valid  in  1  MEM stage holds a real instruction.
- m_regwrite  in  1  instruction writes a GPR.
- m_rd  in  5  destination register number.
- m_wbsel  in  2  writeback source: 0 ALU, 1 MEM, 2 LINK; 3 is reserved and treated as ALU.
- m_ldtype  in  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; other codes are treated as LW.
- m_alu  in  32  ALU result; also the effective address for loads.
- m_pc8  in  32  PC+8, the link value.
- m_rdata  in  32  raw data-memory read word, available in the same cycle as the other m_* inputs.
- gpr_we  out  1  register-file write enable.
- gpr_a3  out  5  register-file write address.
- gpr_wd  out  32  register-file write data.
- adel  out  1  misaligned-load exception pulse.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
Reset
- All internal registers clear to 0.
- gpr_we=0, gpr_a3=0, gpr_wd=0, adel=0, instret=0.
- Reset asserted mid-operation drops the in-flight instruction; no write occurs.

Capture (posedge, not stalled)
- The register loads valid, regwrite, rd, wbsel and the final write data.
- Write data is formed in the capture cycle from m_* inputs. Latency from MEM inputs to gpr_wd is exactly 1 cycle.
- flush=1: captured valid=0, so the instruction is bubbled. flush has priority over stall; flush with stall still clears valid.
- stall=1 and flush=0: contents hold.

First-cycle flag
- A "fresh" flag is set on every non-stalled capture of a valid instruction.
- It clears after one cycle while stalled.
- Effect: a stalled instruction writes and retires exactly once.

Write data
- ALU: m_alu.
- LINK: m_pc8.
- MEM: m_rdata aligned by m_alu[1:0], little-endian (byte k = bits 8k+7:8k).
  - LB/LBU: select byte m_alu[1:0]; sign- or zero-extend to 32 bits.
  - LH/LHU: select halfword m_alu[1]; sign- or zero-extend to 32 bits.
  - LW: full word.

Misalignment
- Misaligned when wbsel=MEM and either:
  - LW with m_alu[1:0]!=0, or
  - LH/LHU with m_alu[0]=1.
- On a misaligned load:
  - captured regwrite is forced to 0;
  - adel=1 for exactly one cycle, the fresh cycle;
  - the instruction still counts as retired.

Outputs
- gpr_we = valid & fresh & regwrite & (rd!=0).
- gpr_a3 = rd.
- gpr_wd = captured data.
- When gpr_we=0, gpr_a3 and gpr_wd hold their last captured values and are don't-care.

instret
- Increments by 1 on every cycle with valid & fresh.
- Wraps modulo 2^CNT_W with no saturation.

Simultaneous events
- Back-to-back valid instructions with no stall produce one write per cycle.
- Writes to r0 retire but never assert gpr_we.

Decomposition:
- Package mips_pkg holds:
  - WBSEL_ALU/MEM/LINK;
  - LD_LW/LH/LHU/LB/LBU encodings;
  - the 5-bit register-index type.
- Sub-module load_align: purely combinational. Inputs are rdata, addr_lo[1:0] and ldtype. Outputs are the aligned data and a misaligned flag. It is instantiated once in wb_stage.

Test Plan:
- Reset released, then m_valid=1, ALU, rd=5, m_alu=0x1234 -> next cycle gpr_we=1, a3=5, wd=0x00001234; instret=1.
- LB with m_rdata=0x80FF7F01, addr_lo=3 -> wd=0xFFFFFF80. Same with LBU -> 0x00000080. LH, addr_lo=2 -> 0xFFFF80FF. LHU, addr_lo=0 -> 0x00007F01.
- LW with m_alu=0x1002 -> adel=1 for one cycle, gpr_we=0, instret increments. LH with m_alu=0x1001 -> same response.
- Valid ALU write to rd=7 followed by stall held for 3 cycles -> gpr_we high only in the first cycle; instret +1 total; wd stable across the stall.
- flush=1 together with stall=1 on a valid write to rd=9 -> no gpr_we; instret unchanged. Write to rd=0 with LINK, m_pc8=0x400008 -> gpr_we=0, instret +1.
- Assert reset asynchronously mid-cycle while gpr_we=1 -> gpr_we, adel and instret go to 0 immediately, before the next clock edge.
